scaler_chain: RTL and testbench

- Synchronous replacement for the AGC scaler divider chain; sits directly downstream of the timer.
- Consumes the timer's FS01_n square wave and counts its rising edges (FS01_n falling) in a binary chain of stages FS02..FS(NSTAGES+1).
- Emits per-stage level outputs and single-cycle set/reset pulses (FnnA, FnnB) for downstream counter-cell, alarm and DSKY timing logic.
- Keeps counting in standby; only an explicit hold stops it.

---
 rtl/scaler_pkg.sv | 21 ++
 rtl/scaler_wdog.sv | 35 +++
 rtl/scaler_chain.sv | 78 +++++++
 tb/tb_scaler_chain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared constants for the AGC scaler divider chain and its consumers.
// Optional watchdog alarm is enabled with SCALER_WDOG_EN.
package scaler_pkg;

  localparam int unsigned NSTAGES_DEFAULT     = 32;
  localparam int unsigned WDOG_CYCLES_DEFAULT = 4096;

  // Stage indices into FS/FA/FB: bit i is stage FS(i+2).
  localparam int unsigned F07_IDX = 5;
  localparam int unsigned F10_IDX = 8;
  localparam int unsigned F17_IDX = 15;

  // Bits needed to hold 0..value-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) res++;
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/scaler_wdog.sv
// Scaler-fail watchdog: counts idle SIM_CLK cycles between FS01 edges and
// raises a sticky alarm. Only compiled when SCALER_WDOG_EN is defined.
`ifdef SCALER_WDOG_EN
module scaler_wdog
  import scaler_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic hold,
  output logic alarm
);

  localparam int unsigned W     = clog2(WDOG_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(WDOG_CYCLES - 1);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      alarm    <= 1'b0;
    end else begin
      // Saturate at the limit so a long outage cannot wrap and hide.
      if (hold || tick) idle_cnt <= '0;
      else if (idle_cnt != LIMIT) idle_cnt <= idle_cnt + ONE;
      if (idle_cnt == LIMIT) alarm <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/scaler_chain.sv
// Synchronous AGC scaler divider chain: counts FS01_n falling edges and emits
// stage levels plus one-cycle set/reset pulses. Watchdog via SCALER_WDOG_EN.
module scaler_chain
  import scaler_pkg::*;
#(
  parameter int unsigned NSTAGES     = NSTAGES_DEFAULT,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic               FS01_n,
  input  logic               SCLHOLD,
  output logic [NSTAGES-1:0] FS,
  output logic [NSTAGES-1:0] FA,
  output logic [NSTAGES-1:0] FB,
  output logic               SCLWRAP,
  output logic               SCAFAL
);

  if (NSTAGES < 1 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("scaler_chain: NSTAGES must be >= 1 and WDOG_CYCLES >= 2");
  end

  localparam logic [NSTAGES-1:0] STEP = NSTAGES'(1);

  logic [NSTAGES-1:0] count;
  logic [NSTAGES-1:0] count_next;
  logic               fs01_n_q;
  logic               armed;
  logic               tick;

  // armed blocks the first clock after reset, so a line already low at
  // release is not taken as a fresh falling edge.
  assign tick       = armed & fs01_n_q & ~FS01_n & ~SCLHOLD;
  assign count_next = count + STEP;
  assign FS         = count;

  // NOTE: non-blocking assignments make every flipping stage and its pulse
  // derive from the same pre-edge count, giving a ripple-free carry.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      fs01_n_q <= 1'b1;
      armed    <= 1'b0;
      count    <= '0;
      FA       <= '0;
      FB       <= '0;
      SCLWRAP  <= 1'b0;
    end else begin
      fs01_n_q <= FS01_n;
      armed    <= 1'b1;
      if (tick) begin
        count   <= count_next;
        FA      <= ~count & count_next;
        FB      <= count & ~count_next;
        SCLWRAP <= &count;
      end else begin
        FA      <= '0;
        FB      <= '0;
        SCLWRAP <= 1'b0;
      end
    end
  end

`ifdef SCALER_WDOG_EN
  scaler_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk  (SIM_CLK),
    .rst_n(SIM_RST),
    .tick (tick),
    .hold (SCLHOLD),
    .alarm(SCAFAL)
  );
`else
  assign SCAFAL = 1'b0;
`endif

endmodule

// File: tb/tb_scaler_chain.sv
// Scoreboard bench for scaler_chain: a 32-stage and a 4-stage instance share
// stimulus; watchdog expectations follow SCALER_WDOG_EN.
module tb_scaler_chain;
  import scaler_pkg::*;

`ifdef SCALER_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic        sim_clk = 1'b0;
  logic        sim_rst;
  logic        fs01_n;
  logic        sclhold;
  logic [31:0] fs32, fa32, fb32;
  logic        wrap32, fal32;
  logic [3:0]  fs4, fa4, fb4;
  logic        wrap4, fal4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] fs32, fa32, fb32;
    logic [3:0]  fs4, fa4, fb4;
    logic        wrap32, wrap4, fal32, fal4;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic        m_prev;
  logic [31:0] m_cnt32;
  logic [3:0]  m_cnt4;
  logic        m_fal32, m_fal4;
  int          m_wd32, m_wd4;

  always #5 sim_clk = ~sim_clk;

  scaler_chain u_dut32 (
    .SIM_CLK(sim_clk), .SIM_RST(sim_rst), .FS01_n(fs01_n), .SCLHOLD(sclhold),
    .FS(fs32), .FA(fa32), .FB(fb32), .SCLWRAP(wrap32), .SCAFAL(fal32)
  );

  scaler_chain #(
    .NSTAGES(4), .WDOG_CYCLES(16)
  ) u_dut4 (
    .SIM_CLK(sim_clk), .SIM_RST(sim_rst), .FS01_n(fs01_n), .SCLHOLD(sclhold),
    .FS(fs4), .FA(fa4), .FB(fb4), .SCLWRAP(wrap4), .SCAFAL(fal4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = 1'b0;
    m_cnt32 = '0;
    m_cnt4  = '0;
    m_fal32 = 1'b0;
    m_fal4  = 1'b0;
    m_wd32  = 0;
    m_wd4   = 0;
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic step(input logic fs_in, input logic hold_in);
    exp_t        e;
    logic        tk;
    logic [31:0] n32;
    logic [3:0]  n4;
    fs01_n  = fs_in;
    sclhold = hold_in;
    tk      = m_prev && !fs_in && !hold_in;
    m_prev  = fs_in;
    n32     = tk ? m_cnt32 + 32'd1 : m_cnt32;
    n4      = tk ? m_cnt4 + 4'd1 : m_cnt4;
    e.fa32  = tk ? (~m_cnt32 & n32) : '0;
    e.fb32  = tk ? (m_cnt32 & ~n32) : '0;
    e.fa4   = tk ? (~m_cnt4 & n4) : '0;
    e.fb4   = tk ? (m_cnt4 & ~n4) : '0;
    e.wrap32 = tk && (n32 == 32'd0);
    e.wrap4  = tk && (n4 == 4'd0);
    if (WDOG_ON) begin
      if (m_wd32 == 4095) m_fal32 = 1'b1;
      if (m_wd4 == 15) m_fal4 = 1'b1;
      m_wd32 = (hold_in || tk) ? 0 : ((m_wd32 < 4095) ? m_wd32 + 1 : 4095);
      m_wd4  = (hold_in || tk) ? 0 : ((m_wd4 < 15) ? m_wd4 + 1 : 15);
    end
    m_cnt32 = n32;
    m_cnt4  = n4;
    e.fs32  = n32;
    e.fs4   = n4;
    e.fal32 = m_fal32;
    e.fal4  = m_fal4;
    exp_q.push_back(e);

    @(posedge sim_clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("fs32", fs32, e.fs32);
      check("fa32", fa32, e.fa32);
      check("fb32", fb32, e.fb32);
      check("wrap32", 32'(wrap32), 32'(e.wrap32));
      check("fal32", 32'(fal32), 32'(e.fal32));
      check("fs4", 32'(fs4), 32'(e.fs4));
      check("fa4", 32'(fa4), 32'(e.fa4));
      check("fb4", 32'(fb4), 32'(e.fb4));
      check("wrap4", 32'(wrap4), 32'(e.wrap4));
      check("fal4", 32'(fal4), 32'(e.fal4));
      check("fa32_onehot", 32'($countones(fa32) <= 1), 32'd1);
      check("fa4_onehot", 32'($countones(fa4) <= 1), 32'd1);
    end
  endtask

  task automatic pulse();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Called just after a step; asserts reset mid-cycle and checks it lands
  // before the next clock edge, then releases it away from the edge.
  task automatic apply_reset();
    #2 sim_rst = 1'b0;
    #1;
    check("rst_fs32", fs32, 32'd0);
    check("rst_fa32", fa32, 32'd0);
    check("rst_fb32", fb32, 32'd0);
    check("rst_fs4", 32'(fs4), 32'd0);
    check("rst_fa4", 32'(fa4), 32'd0);
    check("rst_wrap4", 32'(wrap4), 32'd0);
    check("rst_fal4", 32'(fal4), 32'd0);
    model_reset();
    #1 sim_rst = 1'b1;
  endtask

  initial begin
    sim_rst = 1'b1;
    fs01_n  = 1'b1;
    sclhold = 1'b0;
    model_reset();
    #2 sim_rst = 1'b0;
    #1;
    check("por_fs32", fs32, 32'd0);
    check("por_fa32", fa32, 32'd0);
    check("por_fb32", fb32, 32'd0);
    check("por_wrap32", 32'(wrap32), 32'd0);
    check("por_fal32", 32'(fal32), 32'd0);
    #19 sim_rst = 1'b1;

    // Period-4 square wave, three falling edges.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    check("three_edges_fs32", fs32, 32'd3);
    check("three_edges_fs4", 32'(fs4), 32'd3);

    // Roll the 4-stage chain over.
    while (m_cnt4 != 4'd15) pulse();
    check("pre_wrap_fs4", 32'(fs4), 32'd15);
    pulse();
    check("wrap_fs4", 32'(fs4), 32'd0);
    check("wrap_fb4", 32'(fb4), 32'hf);
    check("wrap_fa4", 32'(fa4), 32'd0);
    check("wrap_flag4", 32'(wrap4), 32'd1);
    step(1'b1, 1'b0);
    check("post_wrap_fb4", 32'(fb4), 32'd0);
    check("post_wrap_flag4", 32'(wrap4), 32'd0);

    // Hold across a falling edge, release while still low.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("hold_fs4", 32'(fs4), 32'd0);
    check("hold_fs32", fs32, 32'd16);
    check("hold_fa32", fa32, 32'd0);
    pulse();
    check("after_hold_fs4", 32'(fs4), 32'd1);
    check("after_hold_fs32", fs32, 32'd17);

    // Async reset while FA[2] is high, then release with FS01_n low.
    while (m_cnt4 != 4'd3) pulse();
    pulse();
    check("fa4_bit2_high", 32'(fa4[2]), 32'd1);
    apply_reset();
    step(1'b0, 1'b0);
    check("no_tick_after_rst", 32'(fs4), 32'd0);
    pulse();
    check("tick_after_rst", 32'(fs4), 32'd1);

    // Watchdog: FS01_n stuck high.
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      if (i == 15) check("wdog_before", 32'(fal4), 32'd0);
      if (i == 16) check("wdog_rise", 32'(fal4), 32'(WDOG_ON));
    end
    pulse();
    pulse();
    check("wdog_sticky", 32'(fal4), 32'(WDOG_ON));
    check("wdog_fal32_quiet", 32'(fal32), 32'd0);

    // Watchdog: held throughout never alarms.
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("wdog_hold_quiet", 32'(fal4), 32'd0);

    // Random toggling with occasional hold.
    apply_reset();
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    check("rand_f07", 32'(fs32[F07_IDX]), 32'(m_cnt32[F07_IDX]));
    check("rand_f10", 32'(fs32[F10_IDX]), 32'(m_cnt32[F10_IDX]));
    check("rand_f17", 32'(fs32[F17_IDX]), 32'(m_cnt32[F17_IDX]));
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
